ewrapper_link_tx_arbiter: RTL and testbench

Weighted round-robin scheduler for the link transmitter's two synchronization FIFOs (write-transaction FIFO and read-request FIFO). It runs on the transmitter clock and decides, every cycle, which FIFO (if any) pops an entry into the txo serializer. Arbitration honours the synchronized per-channel wait flags and the serializer's back-pressure. It replaces the free-running toggle arbitration with per-channel quotas and stall-aware ownership.

---
 rtl/ewrapper_link_tx_arbiter_if.sv | 43 ++++
 rtl/ewrapper_link_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_ewrapper_link_tx_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ewrapper_link_tx_arbiter_if.sv
// ============================================================================
// Module      : ewrapper_link_tx_arbiter_if
// Description : FIFO-status / pop handshake between the link TX arbiter and
//               its write/read synchronization FIFOs and the txo serializer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ewrapper_link_tx_arbiter_if;
  logic wrfifo_empty;
  logic rdfifo_empty;
  logic txo_wr_wait_sync;
  logic txo_rd_wait_sync;
  logic txo_emesh_wait;
  logic wrfifo_rd;
  logic rdfifo_rd;
  logic txo_emesh_access;

  // Arbiter side: observes FIFO/wait status, issues pops
  modport master (
    input  wrfifo_empty,
    input  rdfifo_empty,
    input  txo_wr_wait_sync,
    input  txo_rd_wait_sync,
    input  txo_emesh_wait,
    output wrfifo_rd,
    output rdfifo_rd,
    output txo_emesh_access
  );

  modport slave (
    output wrfifo_empty,
    output rdfifo_empty,
    output txo_wr_wait_sync,
    output txo_rd_wait_sync,
    output txo_emesh_wait,
    input  wrfifo_rd,
    input  rdfifo_rd,
    input  txo_emesh_access
  );
endinterface

`default_nettype wire

// File: rtl/ewrapper_link_tx_arbiter.sv
// ============================================================================
// Module      : ewrapper_link_tx_arbiter
// Description : Weighted round-robin pop scheduler for the link TX write and
//               read FIFOs. Optional grant statistics: EWRAPPER_TX_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ewrapper_link_tx_arbiter #(
  parameter int WR_WEIGHT = 4,
  parameter int RD_WEIGHT = 1,
  parameter int CW        = 4
) (
  input  logic                          txo_lclk,
  input  logic                          reset_n,
  ewrapper_link_tx_arbiter_if.master    bus,
  output logic [1:0]                    arb_state,
  output logic [15:0]                   wr_grant_cnt,
  output logic [15:0]                   rd_grant_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_e;

  localparam logic [CW-1:0] WR_QUOTA = CW'(WR_WEIGHT);
  localparam logic [CW-1:0] RD_QUOTA = CW'(RD_WEIGHT);
  localparam logic          OWNER_WR = 1'b0;
  localparam logic          OWNER_RD = 1'b1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            last_q, last_d;
  logic            wr_elig, rd_elig, both_empty;
  logic            wr_gnt, rd_gnt;

  assign wr_elig    = ~bus.wrfifo_empty & ~bus.txo_wr_wait_sync & ~bus.txo_emesh_wait;
  assign rd_elig    = ~bus.rdfifo_empty & ~bus.txo_rd_wait_sync & ~bus.txo_emesh_wait;
  assign both_empty = bus.wrfifo_empty & bus.rdfifo_empty;
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    wr_gnt  = 1'b0;
    rd_gnt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_elig && (!rd_elig || last_q == OWNER_RD)) begin
          wr_gnt  = 1'b1;
          state_d = ST_WR;
          cnt_d   = CW'(1);
        end else if (rd_elig) begin
          rd_gnt  = 1'b1;
          state_d = ST_RD;
          cnt_d   = CW'(1);
        end
      end
      ST_WR: begin
        if (wr_elig && (!rd_elig || cnt_q < WR_QUOTA)) begin
          wr_gnt = 1'b1;
          cnt_d  = cnt_inc;
        end else if (rd_elig) begin
          rd_gnt  = 1'b1;
          state_d = ST_RD;
          cnt_d   = CW'(1);
          last_d  = OWNER_WR;
        end else if (both_empty) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_RD: begin
        if (rd_elig && (!wr_elig || cnt_q < RD_QUOTA)) begin
          rd_gnt = 1'b1;
          cnt_d  = cnt_inc;
        end else if (wr_elig) begin
          wr_gnt  = 1'b1;
          state_d = ST_WR;
          cnt_d   = CW'(1);
          last_d  = OWNER_RD;
        end else if (both_empty) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge txo_lclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= OWNER_RD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Pops are zero-latency but must vanish the instant reset asserts
  assign bus.wrfifo_rd        = wr_gnt & reset_n;
  assign bus.rdfifo_rd        = rd_gnt & reset_n;
  assign bus.txo_emesh_access = (wr_gnt | rd_gnt) & reset_n;
  assign arb_state            = state_q;

`ifdef EWRAPPER_TX_ARB_STATS_EN
  logic [15:0] wr_stat_q, wr_stat_d;
  logic [15:0] rd_stat_q, rd_stat_d;

  always_comb begin
    wr_stat_d = wr_stat_q + {15'd0, wr_gnt};
    rd_stat_d = rd_stat_q + {15'd0, rd_gnt};
  end

  always_ff @(posedge txo_lclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_stat_q <= '0;
      rd_stat_q <= '0;
    end else begin
      wr_stat_q <= wr_stat_d;
      rd_stat_q <= rd_stat_d;
    end
  end

  assign wr_grant_cnt = wr_stat_q;
  assign rd_grant_cnt = rd_stat_q;
`else
  assign wr_grant_cnt = 16'd0;
  assign rd_grant_cnt = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ewrapper_link_tx_arbiter.sv
// ============================================================================
// Module      : tb_ewrapper_link_tx_arbiter
// Description : Self-checking bench: directed vector table, hand sequences and
//               randomized traffic against a queue-level scheduling model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ewrapper_link_tx_arbiter;
  localparam int WRW = 4;
  localparam int RDW = 1;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  arb_state;
  logic [15:0] wr_grant_cnt, rd_grant_cnt;

  ewrapper_link_tx_arbiter_if bus();

  ewrapper_link_tx_arbiter #(.WR_WEIGHT(WRW), .RD_WEIGHT(RDW), .CW(4)) dut (
    .txo_lclk    (clk),
    .reset_n     (rst_n),
    .bus         (bus),
    .arb_state   (arb_state),
    .wr_grant_cnt(wr_grant_cnt),
    .rd_grant_cnt(rd_grant_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: owner 0 none / 1 write / 2 read; run = consecutive grants to owner
  int m_owner, m_run, m_last, m_wtot, m_rtot;

  typedef struct {
    bit we, re, ww, rw, ew;
    int exp_g;
    int exp_state;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_run = 0; m_last = 2; m_wtot = 0; m_rtot = 0;
  endtask

  task automatic model_step(input bit we, re, ww, rw, ew, output int g);
    bit el[3];
    int other, w;
    el[0] = 1'b0;
    el[1] = !we && !ww && !ew;
    el[2] = !re && !rw && !ew;
    g = 0;
    if (m_owner == 0) begin
      if (el[1] && el[2]) g = (m_last == 2) ? 1 : 2;
      else if (el[1])     g = 1;
      else if (el[2])     g = 2;
      if (g != 0) begin m_owner = g; m_run = 1; end
    end else begin
      other = 3 - m_owner;
      w = (m_owner == 1) ? WRW : RDW;
      if (el[m_owner] && (!el[other] || m_run < w)) begin
        g = m_owner; m_run++;
      end else if (el[other]) begin
        g = other; m_last = m_owner; m_owner = other; m_run = 1;
      end else if (we && re) begin
        m_owner = 0; m_run = 0;
      end
    end
    if (g == 1) m_wtot++;
    if (g == 2) m_rtot++;
  endtask

  // One clock: drive at negedge, check pops before posedge, check state after
  task automatic cycle(input bit we, re, ww, rw, ew, input bit use_tbl,
                       input int tg, input int ts, input string tag, output int g);
    int eg, es;
    @(negedge clk);
    bus.wrfifo_empty = we;  bus.rdfifo_empty = re;
    bus.txo_wr_wait_sync = ww; bus.txo_rd_wait_sync = rw; bus.txo_emesh_wait = ew;
    #1;
    model_step(we, re, ww, rw, ew, g);
    eg = use_tbl ? tg : g;
    es = use_tbl ? ts : m_owner;
    chk({tag, "_wrfifo_rd"}, int'(bus.wrfifo_rd), int'(eg == 1));
    chk({tag, "_rdfifo_rd"}, int'(bus.rdfifo_rd), int'(eg == 2));
    chk({tag, "_access"}, int'(bus.txo_emesh_access), int'(eg != 0));
    @(posedge clk);
    #1;
    chk({tag, "_state"}, int'(arb_state), es);
  endtask

  task automatic chk_stats(input string tag);
`ifdef EWRAPPER_TX_ARB_STATS_EN
    chk({tag, "_wr_grant_cnt"}, int'(wr_grant_cnt), m_wtot & 16'hFFFF);
    chk({tag, "_rd_grant_cnt"}, int'(rd_grant_cnt), m_rtot & 16'hFFFF);
`else
    chk({tag, "_wr_grant_cnt"}, int'(wr_grant_cnt), 0);
    chk({tag, "_rd_grant_cnt"}, int'(rd_grant_cnt), 0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int g, wr_lvl, rd_lvl, nw, nr;
    bus.wrfifo_empty = 1'b0; bus.rdfifo_empty = 1'b0;
    bus.txo_wr_wait_sync = 1'b0; bus.txo_rd_wait_sync = 1'b0; bus.txo_emesh_wait = 1'b0;
    model_reset();

    // Reset state: both FIFOs non-empty, yet no pops while reset_n low
    #2;
    chk("rst_wrfifo_rd", int'(bus.wrfifo_rd), 0);
    chk("rst_rdfifo_rd", int'(bus.rdfifo_rd), 0);
    chk("rst_access", int'(bus.txo_emesh_access), 0);
    chk("rst_state", int'(arb_state), 0);
    chk("rst_wr_grant_cnt", int'(wr_grant_cnt), 0);
    chk("rst_rd_grant_cnt", int'(rd_grant_cnt), 0);
    do_reset();

    // we, re, ww, rw, ew, expected grant (0/1 W/2 R), state after edge
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 2};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 2};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 2};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 2};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 2};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    for (int i = 0; i < 16; i++)
      cycle(tbl[i].we, tbl[i].re, tbl[i].ww, tbl[i].rw, tbl[i].ew, 1'b1,
            tbl[i].exp_g, tbl[i].exp_state, $sformatf("vec%0d", i), g);
    chk_stats("table");

    // Write FIFO alone with 10 entries: ten back-to-back write pops, then IDLE
    do_reset();
    wr_lvl = 10; nw = 0; nr = 0;
    for (int i = 0; i < 13; i++) begin
      cycle(wr_lvl == 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "wronly", g);
      nw += int'(bus.wrfifo_rd);
      nr += int'(bus.rdfifo_rd);
      if (g == 1) wr_lvl--;
    end
    chk("wronly_pops", nw, 10);
    chk("wronly_rd_pops", nr, 0);
    chk("wronly_final_state", int'(arb_state), 0);
    chk_stats("wronly");

    // Reset asserted in the middle of a write run
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "burst", g);
    @(negedge clk);
    #1;
    chk("burst4_wrfifo_rd", int'(bus.wrfifo_rd), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_wrfifo_rd", int'(bus.wrfifo_rd), 0);
    chk("midrst_rdfifo_rd", int'(bus.rdfifo_rd), 0);
    chk("midrst_access", int'(bus.txo_emesh_access), 0);
    chk("midrst_state", int'(arb_state), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, "postrst", g);
    chk("postrst_tie_write", g, 1);

    // Randomized traffic with waits and serializer back-pressure
    do_reset();
    wr_lvl = 0; rd_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) wr_lvl += int'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) rd_lvl += int'($urandom_range(0, 6));
      cycle(wr_lvl == 0, rd_lvl == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0, 1'b0, 0, 0, "rand", g);
      if (g == 1) wr_lvl--;
      if (g == 2) rd_lvl--;
    end
    chk_stats("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
